// File: rtl/npn_tt_sweep_pkg.sv
// npn_tt_pkg: shared types for the truth-table sweeper and its comparator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package npn_tt_pkg;

   localparam int N_IN = 4;
   localparam int TT_W = 16;

   typedef logic [N_IN-1:0] minterm_t;
   typedef logic [TT_W-1:0] tt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/npn_tt_sweep_if.sv
// npn_tt_sweep_if: start/abort control, function-under-test hookup and result bus of the sweeper.
// Latency: n/a (wires only).
// Backpressure: none; start is a request sampled only when the sweeper is idle.
interface npn_tt_sweep_if;
   import npn_tt_pkg::*;

   logic     start_i;
   logic     abort_i;
   minterm_t x_o;
   logic     y_i;
   logic     busy_o;
   logic     done_o;
   tt_t      tt_o;
   tt_t      exp_tt_i;
   logic     match_o;
   minterm_t first_err_o;

   modport master (
      output start_i, abort_i, y_i, exp_tt_i,
      input  x_o, busy_o, done_o, tt_o, match_o, first_err_o
   );

   modport slave (
      input  start_i, abort_i, y_i, exp_tt_i,
      output x_o, busy_o, done_o, tt_o, match_o, first_err_o
   );

endinterface

// File: rtl/npn_tt_sweep_cmp.sv
// npn_tt_cmp: compares a captured truth table with the expected one, reports lowest mismatching minterm.
// Latency: purely combinational.
// Backpressure: none.
module npn_tt_cmp
   import npn_tt_pkg::*;
(
   input  tt_t      i_tt,
   input  tt_t      i_exp,
   output logic     o_match,
   output minterm_t o_first_err
);

   tt_t w_diff;

   // scan from the top down so the lowest differing index is the one left standing
   always_comb begin
      w_diff      = i_tt ^ i_exp;
      o_match     = (w_diff == '0);
      o_first_err = '0;
      for (int i = TT_W - 1; i >= 0; i--) begin
         if (w_diff[i]) begin
            o_first_err = minterm_t'(i);
         end
      end
   end

endmodule

// File: rtl/npn_tt_sweep.sv
// npn_tt_sweep: steps x_o through minterms 0..15, samples y_i after SETTLE_CYCLES each, builds tt_o.
// Latency: done_o pulses 16*SETTLE_CYCLES+1 cycles after the start edge; x_o comes from registers only.
// Backpressure: none; start_i ignored unless idle, abort_i cancels. NPN_TT_SWEEP_CHECK_EN adds the compare.
module npn_tt_sweep
   import npn_tt_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input logic           clk,
   input logic           rst_n,
   npn_tt_sweep_if.slave io_bus
);

   localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
   localparam minterm_t   LAST_IDX   = minterm_t'(TT_W - 1);

   state_t   r_state;
   state_t   w_state_nxt;
   minterm_t r_idx;
   logic [7:0] r_cnt;
   tt_t      r_shadow;
   tt_t      r_tt;
   tt_t      w_tt_fin;
   logic     w_last_sample;
   logic     w_busy;
   logic     w_done;
   minterm_t w_x;

   // the final edge of a sweep that was not aborted
   assign w_last_sample = (r_state == ST_HOLD) && !io_bus.abort_i &&
                          (r_cnt == 8'd0) && (r_idx == LAST_IDX);

   // shadow table with the sample being taken this cycle merged in
   always_comb begin
      w_tt_fin        = r_shadow;
      w_tt_fin[r_idx] = io_bus.y_i;
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state: start wins over abort in IDLE, abort wins over the final sample in HOLD
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (io_bus.start_i) w_state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (io_bus.abort_i) begin
               w_state_nxt = ST_IDLE;
            end else if ((r_cnt == 8'd0) && (r_idx == LAST_IDX)) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // outputs decoded from state registers only
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      w_x    = '0;
      case (r_state)
         ST_HOLD: begin
            w_busy = 1'b1;
            w_x    = r_idx;
         end
         ST_DONE: w_done = 1'b1;
         default: ;
      endcase
   end

   // minterm index, settle counter and shadow accumulation; tt_o only moves on a full sweep
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx    <= '0;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_tt     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (io_bus.start_i) begin
                  r_idx    <= '0;
                  r_cnt    <= CNT_RELOAD;
                  r_shadow <= '0;
               end
            end
            ST_HOLD: begin
               if (!io_bus.abort_i) begin
                  if (r_cnt == 8'd0) begin
                     r_shadow <= w_tt_fin;
                     r_cnt    <= CNT_RELOAD;
                     r_idx    <= r_idx + 1'b1;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end
            default: ;
         endcase
         if (w_last_sample) begin
            r_tt <= w_tt_fin;
         end
      end
   end

   assign io_bus.x_o    = w_x;
   assign io_bus.busy_o = w_busy;
   assign io_bus.done_o = w_done;
   assign io_bus.tt_o   = r_tt;

`ifdef NPN_TT_SWEEP_CHECK_EN
   tt_t      r_exp;
   logic     r_match;
   minterm_t r_ferr;
   logic     w_match;
   minterm_t w_ferr;

   npn_tt_cmp u_cmp (
      .i_tt        (w_tt_fin),
      .i_exp       (r_exp),
      .o_match     (w_match),
      .o_first_err (w_ferr)
   );

   // expected table latched at start, verdict captured alongside the final table
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_exp   <= '0;
         r_match <= 1'b0;
         r_ferr  <= '0;
      end else begin
         if ((r_state == ST_IDLE) && io_bus.start_i) begin
            r_exp <= io_bus.exp_tt_i;
         end
         if (w_last_sample) begin
            r_match <= w_match;
            r_ferr  <= w_ferr;
         end
      end
   end

   assign io_bus.match_o     = r_match;
   assign io_bus.first_err_o = r_ferr;
`else
   tt_t w_unused_exp;
   assign w_unused_exp       = io_bus.exp_tt_i;
   assign io_bus.match_o     = 1'b0;
   assign io_bus.first_err_o = '0;
`endif

endmodule

// File: tb/tb_npn_tt_sweep.sv
// tb_npn_tt_sweep: two sweepers (S=1 and S=3) each wired to a selectable 4-input function.
// A cycle-count model predicts every output each cycle; directed scenarios add literal expectations.
// Inputs change 1 time unit after the rising edge, outputs are compared on the falling edge.
module tb_npn_tt_sweep;
   import npn_tt_pkg::*;

   localparam int NI = 2;
   localparam int S0 = 1;
   localparam int S1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start   [NI];
   logic        abort   [NI];
   logic [15:0] exp_tt  [NI];
   logic [1:0]  fsel    [NI];

   logic [3:0]  x_w     [NI];
   logic        busy_w  [NI];
   logic        done_w  [NI];
   logic [15:0] tt_w    [NI];
   logic        match_w [NI];
   logic [3:0]  ferr_w  [NI];

   int n_chk = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   // function under test: 0 -> x0, 1 -> parity, 2 -> AND4, 3 -> constant 1
   function automatic logic fn(input logic [1:0] sel, input logic [3:0] x);
      case (sel)
         2'd0:    return x[0];
         2'd1:    return ^x;
         2'd2:    return &x;
         default: return 1'b1;
      endcase
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      npn_tt_sweep_if bus ();
      npn_tt_sweep #(.SETTLE_CYCLES(g == 0 ? S0 : S1)) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .io_bus (bus)
      );
      assign bus.start_i  = start[g];
      assign bus.abort_i  = abort[g];
      assign bus.exp_tt_i = exp_tt[g];
      assign bus.y_i      = fn(fsel[g], bus.x_o);
      assign x_w[g]       = bus.x_o;
      assign busy_w[g]    = bus.busy_o;
      assign done_w[g]    = bus.done_o;
      assign tt_w[g]      = bus.tt_o;
      assign match_w[g]   = bus.match_o;
      assign ferr_w[g]    = bus.first_err_o;
   end

   function automatic int s_of(input int g);
      return (g == 0) ? S0 : S1;
   endfunction

   function automatic logic [15:0] full_tt(input logic [1:0] sel);
      logic [15:0] t;
      for (int i = 0; i < 16; i++) t[i] = fn(sel, 4'(i));
      return t;
   endfunction

   function automatic logic [3:0] lowest_diff(input logic [15:0] a, input logic [15:0] b);
      for (int i = 0; i < 16; i++) if (a[i] != b[i]) return 4'(i);
      return 4'd0;
   endfunction

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s[dut%0d] @%0t: got %0h, expected %0h", nm, g, $time, act, req);
      end
   endtask

   // model: k = position within a sweep (0 idle, 1..16S holding, 16S+1 done)
   int          k       [NI];
   logic [15:0] m_tt    [NI];
   logic [15:0] m_exp   [NI];
   logic        m_match [NI];
   logic [3:0]  m_ferr  [NI];

   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (!rst_n) begin
            k[g]       <= 0;
            m_tt[g]    <= '0;
            m_match[g] <= 1'b0;
            m_ferr[g]  <= '0;
         end else if (k[g] == 0) begin
            if (start[g]) begin
               k[g]     <= 1;
               m_exp[g] <= exp_tt[g];
            end
         end else if (k[g] <= 16 * s_of(g)) begin
            if (abort[g]) begin
               k[g] <= 0;
            end else begin
               k[g] <= k[g] + 1;
               if (k[g] == 16 * s_of(g)) begin
                  m_tt[g] <= full_tt(fsel[g]);
`ifdef NPN_TT_SWEEP_CHECK_EN
                  m_match[g] <= (full_tt(fsel[g]) == m_exp[g]);
                  m_ferr[g]  <= lowest_diff(full_tt(fsel[g]), m_exp[g]);
`endif
               end
            end
         end else begin
            k[g] <= 0;
         end
      end
   end

   // compare every output of both sweepers against the model each cycle
   always @(negedge clk) begin
      if (chk_en) begin
         for (int g = 0; g < NI; g++) begin
            logic eb;
            eb = (k[g] >= 1) && (k[g] <= 16 * s_of(g));
            chk("busy_o", g, 32'(busy_w[g]), 32'(eb));
            chk("x_o", g, 32'(x_w[g]), eb ? 32'((k[g] - 1) / s_of(g)) : 32'd0);
            chk("done_o", g, 32'(done_w[g]), 32'(k[g] == 16 * s_of(g) + 1));
            chk("tt_o", g, 32'(tt_w[g]), 32'(m_tt[g]));
            chk("match_o", g, 32'(match_w[g]), 32'(m_match[g]));
            chk("first_err_o", g, 32'(ferr_w[g]), 32'(m_ferr[g]));
         end
      end
   end

   logic [3:0] rec_x    [0:127];
   logic       rec_busy [0:127];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // pulse start on dut g, follow it to done_o; dc = cycle of done_o counted from the start edge
   task automatic run(input int g, input int bound, output int dc, output int busy_n);
      int c;
      start[g] = 1'b1;
      tick();
      start[g] = 1'b0;
      c = 1;
      busy_n = 0;
      while (c < bound && !done_w[g]) begin
         rec_x[c]    = x_w[g];
         rec_busy[c] = busy_w[g];
         if (busy_w[g]) busy_n++;
         tick();
         c++;
      end
      if (!done_w[g]) chk("done_seen", g, 32'(done_w[g]), 32'd1);
      dc = c;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      n_err++;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dc, bn, nd;
      rst_n = 1'b0;
      for (int g = 0; g < NI; g++) begin
         start[g] = 1'b0; abort[g] = 1'b0; exp_tt[g] = '0; fsel[g] = 2'd0;
      end
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_tt", 0, 32'(tt_w[0]), 32'h0);
      chk("rst_busy", 1, 32'(busy_w[1]), 32'h0);
      chk("rst_x", 0, 32'(x_w[0]), 32'h0);
      rst_n = 1'b1;
      tick();

      // S=1, y = x0
      fsel[0] = 2'd0;
      run(0, 40, dc, bn);
      chk("A_done_cycle", 0, 32'(dc), 32'd17);
      chk("A_tt", 0, 32'(tt_w[0]), 32'hAAAA);
      chk("A_busy_cycles", 0, 32'(bn), 32'd16);
      chk("A_x_cyc1", 0, 32'(rec_x[1]), 32'd0);
      chk("A_x_cyc8", 0, 32'(rec_x[8]), 32'd7);
      chk("A_x_cyc16", 0, 32'(rec_x[16]), 32'd15);

      // start asserted in the cycle after done_o
      tick();
      chk("F_idle_busy", 0, 32'(busy_w[0]), 32'd0);
      run(0, 40, dc, bn);
      chk("F_busy_cyc1", 0, 32'(rec_busy[1]), 32'd1);
      chk("F_x_cyc1", 0, 32'(rec_x[1]), 32'd0);
      chk("F_done_cycle", 0, 32'(dc), 32'd17);
      tick();

      // S=3, parity
      fsel[1] = 2'd1;
      run(1, 80, dc, bn);
      chk("B_done_cycle", 1, 32'(dc), 32'd49);
      chk("B_tt", 1, 32'(tt_w[1]), 32'h6996);
      chk("B_busy_cycles", 1, 32'(bn), 32'd48);
      chk("B_x_cyc4", 1, 32'(rec_x[4]), 32'd1);
      chk("B_x_cyc48", 1, 32'(rec_x[48]), 32'd15);
      tick();

      // AND4 against an expected table
      fsel[0] = 2'd2;
      exp_tt[0] = 16'h8000;
      run(0, 40, dc, bn);
      exp_tt[0] = 16'h0000;
      chk("C1_tt", 0, 32'(tt_w[0]), 32'h8000);
`ifdef NPN_TT_SWEEP_CHECK_EN
      chk("C1_match", 0, 32'(match_w[0]), 32'd1);
`else
      chk("C1_match", 0, 32'(match_w[0]), 32'd0);
`endif
      tick();
      exp_tt[0] = 16'h8010;
      run(0, 40, dc, bn);
`ifdef NPN_TT_SWEEP_CHECK_EN
      chk("C2_match", 0, 32'(match_w[0]), 32'd0);
      chk("C2_first_err", 0, 32'(ferr_w[0]), 32'd4);
`else
      chk("C2_match", 0, 32'(match_w[0]), 32'd0);
      chk("C2_first_err", 0, 32'(ferr_w[0]), 32'd0);
`endif
      tick();

      // abort in cycle 7 of a y=1 sweep keeps the previous table
      fsel[1] = 2'd3;
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      repeat (6) tick();
      abort[1] = 1'b1;
      tick();
      abort[1] = 1'b0;
      chk("D_busy_after_abort", 1, 32'(busy_w[1]), 32'd0);
      nd = 0;
      repeat (60) begin
         if (done_w[1]) nd++;
         tick();
      end
      chk("D_done_count", 1, 32'(nd), 32'd0);
      chk("D_tt_kept", 1, 32'(tt_w[1]), 32'h6996);

      // synchronous reset in cycle 5 of a sweep
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      chk("E_rst_busy", 0, 32'(busy_w[0]), 32'd0);
      chk("E_rst_x", 0, 32'(x_w[0]), 32'd0);
      chk("E_rst_tt0", 0, 32'(tt_w[0]), 32'h0);
      chk("E_rst_tt1", 1, 32'(tt_w[1]), 32'h0);
      chk("E_rst_done", 0, 32'(done_w[0]), 32'd0);
      rst_n = 1'b1;
      tick();

      // start again mid-sweep is ignored: exactly one done_o
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      nd = 0;
      repeat (30) begin
         if (done_w[0]) nd++;
         tick();
      end
      chk("E_done_count", 0, 32'(nd), 32'd1);
      chk("E_tt", 0, 32'(tt_w[0]), 32'h8000);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/npn_tt_sweep.md
# npn_tt_sweep

Sequential truth-table sweeper that sits directly upstream and downstream of a 4-input, single-output combinational NPN function block. It drives all 16 input minterms onto the block's inputs in order and samples its output after a configurable settle time. It then assembles the samples into a 16-bit truth table and reports completion with a start/busy/done handshake. It is used to characterise and regress synthesised 4-input functions in simulation and on FPGA.

## Interface
- SETTLE_CYCLES, default 1 — cycles each minterm is held before the output is sampled; legal range 1..255.
- clk  input  1  sole clock, all state on rising edge.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- start_i  input  1  request a sweep; sampled only in IDLE.
- abort_i  input  1  cancel a running sweep.
- x_o  output  4  minterm driven to the function; x_o[0] is x0 (LSB) … x_o[3] is x3.
- y_i  input  1  function output y0.
- busy_o  output  1  sweep in progress.
- done_o  output  1  one-cycle pulse when the sweep is complete.
- tt_o  output  16  captured truth table; tt_o[i] = y0 for x_o == i.
- exp_tt_i  input  16  expected table (check feature only).
- match_o  output  1  tt_o equals the expected table (check feature only).
- first_err_o  output  4  lowest mismatching minterm index (check feature only).

## Operation
- States: IDLE, HOLD, DONE.
- IDLE: x_o = 0, busy_o = 0.
  - start_i = 1 → HOLD; idx = 0; settle counter = SETTLE_CYCLES-1; tt cleared to 0; exp_tt_i latched.
- HOLD: x_o = idx, busy_o = 1.
  - Counter decrements each cycle.
  - At counter == 0, y_i is written to tt[idx] on that edge.
  - If idx == 15, go to DONE. Otherwise idx increments and the counter reloads.
- DONE: exactly one cycle. done_o = 1, busy_o = 0, x_o = 0; then go to IDLE.
- tt_o and match_o/first_err_o are updated only at the end of a complete sweep. They hold until the next completed sweep or reset. Partial results are never visible on tt_o, because bits accumulate in an internal shadow register.
- abort_i in HOLD → IDLE next cycle. There is no done_o pulse, and tt_o keeps its previous value. abort_i has priority over the final sample.
- start_i while in HOLD or DONE is ignored and is not queued.
- start_i and abort_i together in IDLE: start wins.

## Timing
- Reset values:
  - x_o = 0, busy_o = 0, done_o = 0, tt_o = 16'h0000, match_o = 0, first_err_o = 0.
  - State IDLE; idx and counter 0.
- Reset mid-sweep returns to these values on the next edge with no done_o pulse.
- The start edge occurs at cycle 0. x_o = 0 and busy_o = 1 from cycle 1.
- Minterm i is driven during cycles 1+i·S … S+i·S (S = SETTLE_CYCLES), and y_i is sampled at the last of those edges.
- done_o is high in cycle 16·S+1. tt_o and match_o are valid from that same cycle.
- Latency from start to done is 16·S+1 cycles. Back-to-back: a new start is accepted in cycle 16·S+2 at the earliest.
- x_o is registered. y_i must be stable within S cycles, which includes one cycle of combinational settle for S = 1.

## Configuration
- NPN_TT_SWEEP_CHECK_EN defined:
  - exp_tt_i is latched at start.
  - At DONE, match_o = (table == latched expected).
  - first_err_o = lowest index where they differ, or 0 if they match.
- Undefined: exp_tt_i is ignored, match_o and first_err_o are tied 0, and the comparator logic is not synthesised. Ports remain present in both cases.

## Structure
- Shared package npn_tt_pkg:
  - state enum (IDLE, HOLD, DONE);
  - localparams N_IN = 4 and TT_W = 16;
  - typedefs minterm_t (logic [3:0]) and tt_t (logic [15:0]).
- One sub-module, npn_tt_cmp: compares tt_t against the expected table and returns match plus a priority-encoded first mismatch index. It is instantiated only under NPN_TT_SWEEP_CHECK_EN.
- The function under test is external and connected by the bench or a wrapper.

## Test plan
- y_i = x0 (AND4 check below uses &x), S = 1: start → x_o steps 0..15 in cycles 1..16; done_o in cycle 17; tt_o = 16'hAAAA.
- y_i = ^x_o, S = 3: done_o in cycle 49; tt_o = 16'h6996; busy_o high cycles 1..48.
- y_i = &x_o, check enabled, exp_tt_i = 16'h8000 → match_o = 1; rerun with exp_tt_i = 16'h8010 → match_o = 0, first_err_o = 4.
- Abort in cycle 7 of a sweep with y_i = 1 after a prior tt_o = 16'h6996 → IDLE, no done_o, tt_o stays 16'h6996.
- rst_n low in cycle 5 of a sweep → all outputs at reset values next cycle; a start pulse during HOLD is ignored and done_o pulses exactly once.
- Start asserted in the cycle after done_o → new sweep begins with x_o = 0 one cycle later.
